// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) with HI/LO registers.
// One iteration per clock: shift-add multiply or restoring divide, then one sign-fix cycle.
module mul_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             HiWrite,
    input  logic             LoWrite,
    input  logic [WIDTH-1:0] WriteData,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             neg_lo;     // negate full product (mult) or quotient (div)
    logic             neg_hi;     // negate remainder (div only)
    logic             div_zero;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] opnd;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc_hi;     // product high half / partial remainder
    logic [WIDTH-1:0] acc_lo;     // multiplier / dividend shifting into quotient

    logic             signed_op;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] div_rem_nxt;
    logic [WIDTH-1:0] div_quo_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] fix_hi;
    logic [WIDTH-1:0] fix_lo;

    // NOTE: every signal driven here gets a default first, so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        signed_op = ~Op[0];
        abs_a     = (signed_op && A[WIDTH-1]) ? -A : A;
        abs_b     = (signed_op && B[WIDTH-1]) ? -B : B;

        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

        // Partial remainder is always below the divisor, so the shifted value fits
        // in WIDTH+1 bits and the top bit of the difference is the borrow.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        if (!div_diff[WIDTH]) begin
            div_rem_nxt = div_diff[WIDTH-1:0];
            div_quo_nxt = {acc_lo[WIDTH-2:0], 1'b1};
        end else begin
            div_rem_nxt = div_shift[WIDTH-1:0];
            div_quo_nxt = {acc_lo[WIDTH-2:0], 1'b0};
        end

        prod   = {acc_hi, acc_lo};
        fix_hi = acc_hi;
        fix_lo = acc_lo;
        if (!is_div) begin
            if (neg_lo) {fix_hi, fix_lo} = -prod;
        end else if (div_zero) begin
            fix_hi = a_raw;
            fix_lo = '1;
        end else begin
            if (neg_lo) fix_lo = -acc_lo;
            if (neg_hi) fix_hi = -acc_hi;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            a_raw    <= '0;
            opnd     <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        is_div   <= Op[1];
                        a_raw    <= A;
                        cnt      <= '0;
                        acc_hi   <= '0;
                        if (Op[1]) begin
                            acc_lo <= abs_a;
                            opnd   <= abs_b;
                        end else begin
                            acc_lo <= abs_b;
                            opnd   <= abs_a;
                        end
                        neg_lo   <= signed_op && (A[WIDTH-1] ^ B[WIDTH-1]);
                        neg_hi   <= signed_op && Op[1] && A[WIDTH-1];
                        div_zero <= Op[1] && (B == '0);
                        Busy     <= 1'b1;
                        state    <= S_RUN;
                    end else begin
                        if (HiWrite) Hi <= WriteData;
                        if (LoWrite) Lo <= WriteData;
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        acc_hi <= div_rem_nxt;
                        acc_lo <= div_quo_nxt;
                    end else begin
                        acc_hi <= mul_sum[WIDTH:1];
                        acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                    end
                    if (cnt == LAST_ITER) state <= S_FIX;
                    else                  cnt   <= cnt + 1'b1;
                end
                S_FIX: begin
                    Hi    <= fix_hi;
                    Lo    <= fix_lo;
                    Done  <= 1'b1;
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic reference model.
module tb_mul_div_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        HiWrite;
    logic        LoWrite;
    logic [31:0] WriteData;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int errors = 0;
    int checks = 0;

    mul_div_unit dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .HiWrite   (HiWrite),
        .LoWrite   (LoWrite),
        .WriteData (WriteData),
        .Busy      (Busy),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: {hi, lo} from ordinary 64-bit integer arithmetic.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (op)
            OP_MULT:  begin sp = sa * sb; res = sp; end
            OP_MULTU: res = ua * ub;
            OP_DIV: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (b == 32'd0) res = {a, 32'hFFFF_FFFF};
                else res = {32'(ua % ub), 32'(ua / ub)};
            end
        endcase
        return res;
    endfunction

    // Called at a negedge. Issues one op, checks hold/latency/busy width and result.
    // Returns at the negedge where Done is high.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit check_tail);
        logic [63:0] exp;
        logic [31:0] prev_hi, prev_lo;
        int edges, busy_cnt;
        exp     = model(op, a, b);
        prev_hi = Hi;
        prev_lo = Lo;
        Start = 1'b1; Op = op; A = a; B = b;
        @(negedge Clk);
        Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
        A = $urandom; B = $urandom; Op = 2'($urandom);
        check({tag, " hold"}, {Hi, Lo}, {prev_hi, prev_lo});
        edges = 1;
        busy_cnt = 0;
        while (!Done && edges < 100) begin
            if (Busy) busy_cnt++;
            @(negedge Clk);
            edges++;
        end
        check({tag, " latency"}, 64'(edges), 64'd34);
        check({tag, " busy_cycles"}, 64'(busy_cnt), 64'd33);
        check({tag, " hilo"}, {Hi, Lo}, exp);
        if (check_tail) begin
            @(negedge Clk);
            check({tag, " done_width"}, {62'd0, Done, Busy}, 64'd0);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        Rst = 1'b1; Start = 1'b0; Op = '0; A = '0; B = '0;
        HiWrite = 1'b0; LoWrite = 1'b0; WriteData = '0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        check("reset", {28'd0, Busy, Done, 2'd0, Hi}, 64'd0);
        check("reset lo", {32'd0, Lo}, 64'd0);

        do_op("mult_neg3x5",  OP_MULT,  32'hFFFF_FFFD, 32'd5, 1'b1);
        do_op("multu_ff",     OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op("mult_ff",      OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        do_op("div_neg7_2",   OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);
        do_op("divu_100_7",   OP_DIVU,  32'd100, 32'd7, 1'b1);
        do_op("divu_by0",     OP_DIVU,  32'h64, 32'd0, 1'b1);
        do_op("div_by0",      OP_DIV,   32'hFFFF_FF00, 32'd0, 1'b1);
        do_op("div_min_neg1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b1);

        // MTHI/MTLO in idle, individually and together.
        WriteData = 32'hA5A5_0001; HiWrite = 1'b1;
        @(negedge Clk);
        HiWrite = 1'b0;
        check("mthi", {32'd0, Hi}, 64'hA5A5_0001);
        WriteData = 32'h0BAD_F00D; HiWrite = 1'b1; LoWrite = 1'b1;
        @(negedge Clk);
        HiWrite = 1'b0; LoWrite = 1'b0;
        check("mthi_mtlo", {Hi, Lo}, 64'h0BAD_F00D_0BAD_F00D);

        // Start wins over a simultaneous MTHI/MTLO.
        HiWrite = 1'b1; LoWrite = 1'b1; WriteData = 32'hBEEF;
        do_op("start_wins", OP_DIVU, 32'd100, 32'd7, 1'b1);

        // Start and MTHI while busy are ignored.
        Start = 1'b1; Op = OP_MULT; A = 32'd6; B = 32'd7;
        @(negedge Clk);
        Start = 1'b0;
        repeat (9) @(negedge Clk);
        Start = 1'b1; Op = OP_DIV; A = 32'd99; B = 32'd3;
        HiWrite = 1'b1; WriteData = 32'hDEAD;
        @(negedge Clk);
        Start = 1'b0; HiWrite = 1'b0;
        begin
            int guard = 0;
            while (!Done && guard < 60) begin
                @(negedge Clk);
                guard++;
            end
            check("busy_ignore done_seen", {63'd0, Done}, 64'd1);
        end
        check("busy_ignore hilo", {Hi, Lo}, 64'd42);
        @(negedge Clk);
        check("busy_ignore no_second", {62'd0, Done, Busy}, 64'd0);
        LoWrite = 1'b1; WriteData = 32'h1234;
        @(negedge Clk);
        LoWrite = 1'b0;
        check("mtlo_after", {Hi, Lo}, 64'h1234);

        // Reset mid-operation aborts; a new Start right after completes normally.
        Start = 1'b1; Op = OP_DIVU; A = 32'd1000; B = 32'd3;
        @(negedge Clk);
        Start = 1'b0;
        repeat (11) @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        Rst = 1'b0;
        check("midop_reset", {28'd0, Busy, Done, 2'd0, Hi}, 64'd0);
        check("midop_reset lo", {32'd0, Lo}, 64'd0);
        do_op("after_reset", OP_MULT, 32'hFFFF_FFF0, 32'd3, 1'b1);

        // Back-to-back: second Start issued in the Done cycle.
        do_op("b2b_first",  OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        do_op("b2b_second", OP_DIV,   32'h8000_0001, 32'd7, 1'b1);

        for (int i = 0; i < 24; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom);
            ra  = pick();
            rb  = pick();
            do_op($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, i[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
